pc_sequencer: RTL

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 127 ++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: issues instruction fetches, holds the fetched
// instruction for decode, and applies control-flow redirects. Redirects that
// arrive while a fetch is outstanding mark that fetch as killed so its data
// is dropped and the redirect target is fetched instead.
module pc_sequencer #(
    parameter logic [29:0] RESET_PC = 30'h0000_0C00
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [29:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [29:0] inst_pc,
    input  logic        inst_ready,
    input  logic        redir_valid,
    input  logic [1:0]  redir_op,
    input  logic [29:0] redir_pc,
    input  logic [25:0] imm26,
    input  logic [31:0] aluout
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t      state_q;
    logic [29:0] pc_q;
    logic [31:0] inst_q;
    logic [29:0] inst_pc_q;
    logic        req_q;
    logic        valid_q;
    logic        kill_q;
    logic [29:0] pend_q;

    logic [29:0] redir_tgt;
    logic        redir_go;

    // The low two bits of a register target are a byte offset within the word.
    logic unused_alu_lsbs;
    assign unused_alu_lsbs = ^aluout[1:0];

    // Redirect target selection; op 00 never counts as a redirect.
    always_comb begin
        redir_tgt = '0;
        unique case (redir_op)
            2'b01:   redir_tgt = redir_pc + 30'd1 + {{14{imm26[15]}}, imm26[15:0]};
            2'b10:   redir_tgt = {redir_pc[29:26], imm26};
            2'b11:   redir_tgt = aluout[31:2];
            default: redir_tgt = '0;
        endcase
        redir_go = redir_valid && (redir_op != 2'b00);
    end

    // Fetch/hold FSM with registered request/valid flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pc_q      <= RESET_PC;
            inst_q    <= '0;
            inst_pc_q <= '0;
            req_q     <= 1'b0;
            valid_q   <= 1'b0;
            kill_q    <= 1'b0;
            pend_q    <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_q <= ST_FETCH;
                    req_q   <= 1'b1;
                    valid_q <= 1'b0;
                end
                ST_FETCH: begin
                    if (imem_ack) begin
                        if (redir_go) begin
                            // Coincident redirect wins over any pending target.
                            pc_q   <= redir_tgt;
                            kill_q <= 1'b0;
                        end else if (kill_q) begin
                            pc_q   <= pend_q;
                            kill_q <= 1'b0;
                        end else begin
                            inst_q    <= imem_data;
                            inst_pc_q <= pc_q;
                            pc_q      <= pc_q + 30'd1;
                            state_q   <= ST_HOLD;
                            req_q     <= 1'b0;
                            valid_q   <= 1'b1;
                        end
                    end else if (redir_go) begin
                        // Address stays put until the outstanding fetch returns.
                        pend_q <= redir_tgt;
                        kill_q <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (redir_go) begin
                        pc_q    <= redir_tgt;
                        state_q <= ST_FETCH;
                        req_q   <= 1'b1;
                        valid_q <= 1'b0;
                    end else if (inst_ready) begin
                        state_q <= ST_FETCH;
                        req_q   <= 1'b1;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req   = req_q;
    assign imem_addr  = pc_q;
    assign inst_valid = valid_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;

endmodule
